// File: rtl/alu_pkg.sv
// Shared opcode, PSR bit and FSM definitions for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_MULT = 3'b110;
    localparam logic [2:0] OP_CMP  = 3'b111;

    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic logic [4:0] pack_psr(input logic n, input logic z, input logic f,
                                            input logic l, input logic c);
        logic [4:0] p;
        p        = '0;
        p[PSR_N] = n;
        p[PSR_Z] = z;
        p[PSR_F] = f;
        p[PSR_L] = l;
        p[PSR_C] = c;
        return p;
    endfunction

endpackage

// File: rtl/alu_mult_iter.sv
// LSB-first shift-add multiplier, one multiplier bit per cycle.
// With ALU_MULHI_EN defined the full 2*WIDTH product is kept; otherwise only the low half.
module alu_mult_iter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
`ifdef ALU_MULHI_EN
    output logic [2*WIDTH-1:0] prod_o
`else
    output logic [WIDTH-1:0]   prod_o
`endif
);

`ifdef ALU_MULHI_EN
    localparam int PW = 2*WIDTH;
`else
    localparam int PW = WIDTH;
`endif

    logic [PW-1:0]    acc_q, acc_d, mcand_q, mcand_d, src_acc, src_mcand;
    logic [WIDTH-1:0] mplier_q, mplier_d, src_mplier;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic             step;

    assign done_o = run_q && (cnt_q == CNT_W'(WIDTH));
    assign busy_o = run_q;
    assign prod_o = acc_q;
    assign step   = run_q && !done_o;

    // The first iteration is folded into the start edge so the last bit lands WIDTH-1 edges later.
    always_comb begin
        src_acc    = start_i ? '0 : acc_q;
        src_mcand  = start_i ? PW'(a_i) : mcand_q;
        src_mplier = start_i ? b_i : mplier_q;
        acc_d      = src_acc + (src_mplier[0] ? src_mcand : '0);
        mcand_d    = src_mcand << 1;
        mplier_d   = src_mplier >> 1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start_i) begin
            run_q <= 1'b1;
            cnt_q <= CNT_W'(1);
        end else if (step) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (done_o) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (start_i || step) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides; MULT runs on the iterative multiplier.
// Optional ALU_MULHI_EN adds result_hi (upper product half) and sets MULT F on a non-zero upper half.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       aluop,
    input  logic [WIDTH-1:0] arg1,
    input  logic [WIDTH-1:0] arg2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
`ifdef ALU_MULHI_EN
    output logic [4:0]       PSRwrite,
    output logic [WIDTH-1:0] result_hi
`else
    output logic [4:0]       PSRwrite
`endif
);

    state_e           state_q, state_d;
    logic             accept, is_mult, mult_start, mult_busy, mult_done;
    logic [WIDTH-1:0] result_q, alu_res, mul_lo;
    logic [4:0]       psr_q, alu_psr, mul_psr;
    logic [WIDTH:0]   sum, diff;
    logic             mul_f;
`ifdef ALU_MULHI_EN
    logic [2*WIDTH-1:0] mult_prod;
    logic [WIDTH-1:0]   hi_q;
`else
    logic [WIDTH-1:0]   mult_prod;
`endif

    alu_mult_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mult (
        .clk     (clk),
        .reset   (reset),
        .start_i (mult_start),
        .a_i     (arg1),
        .b_i     (arg2),
        .busy_o  (mult_busy),
        .done_o  (mult_done),
        .prod_o  (mult_prod)
    );

    assign is_mult = (aluop == OP_MULT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = is_mult ? MUL : DONE;
            MUL:     if (mult_done) state_d = DONE;
            DONE:    if (out_ready) state_d = accept ? (is_mult ? MUL : DONE) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = ((state_q == IDLE) && !mult_busy) || ((state_q == DONE) && out_ready);
        out_valid  = (state_q == DONE);
        accept     = in_valid && in_ready;
        mult_start = accept && is_mult;
    end

    // Single-cycle ops: widened add/sub expose carry and borrow in the top bit.
    always_comb begin
        sum     = {1'b0, arg1} + {1'b0, arg2};
        diff    = {1'b0, arg1} - {1'b0, arg2};
        alu_res = '0;
        alu_psr = '0;
        case (aluop)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_psr = pack_psr(alu_res[WIDTH-1], alu_res == '0,
                                   (arg1[WIDTH-1] == arg2[WIDTH-1]) && (alu_res[WIDTH-1] != arg1[WIDTH-1]),
                                   1'b0, sum[WIDTH]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_psr = pack_psr(alu_res[WIDTH-1], alu_res == '0,
                                   (arg1[WIDTH-1] != arg2[WIDTH-1]) && (alu_res[WIDTH-1] != arg1[WIDTH-1]),
                                   1'b0, diff[WIDTH]);
            end
            OP_CMP: begin
                alu_res = arg1;
                alu_psr = pack_psr($signed(arg1) < $signed(arg2), arg1 == arg2, 1'b0,
                                   arg1 < arg2, 1'b0);
            end
            default: begin
                case (aluop)
                    OP_OR:   alu_res = arg1 | arg2;
                    OP_AND:  alu_res = arg1 & arg2;
                    OP_XOR:  alu_res = arg1 ^ arg2;
                    default: alu_res = ~arg1;
                endcase
                alu_psr = pack_psr(alu_res[WIDTH-1], alu_res == '0, 1'b0, 1'b0, 1'b0);
            end
        endcase
    end

    always_comb begin
        mul_lo = mult_prod[WIDTH-1:0];
`ifdef ALU_MULHI_EN
        mul_f  = |mult_prod[2*WIDTH-1:WIDTH];
`else
        mul_f  = 1'b0;
`endif
        mul_psr = pack_psr(mul_lo[WIDTH-1], mul_lo == '0, mul_f, 1'b0, 1'b0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            psr_q    <= '0;
`ifdef ALU_MULHI_EN
            hi_q     <= '0;
`endif
        end else if (accept && !is_mult) begin
            result_q <= alu_res;
            psr_q    <= alu_psr;
`ifdef ALU_MULHI_EN
            hi_q     <= '0;
`endif
        end else if ((state_q == MUL) && mult_done) begin
            result_q <= mul_lo;
            psr_q    <= mul_psr;
`ifdef ALU_MULHI_EN
            hi_q     <= mult_prod[2*WIDTH-1:WIDTH];
`endif
        end
    end

    assign result   = result_q;
    assign PSRwrite = psr_q;
`ifdef ALU_MULHI_EN
    assign result_hi = hi_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed test-plan steps plus random ops against an arithmetic model.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   aluop = 3'd0;
    logic [W-1:0] arg1 = '0;
    logic [W-1:0] arg2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [4:0]   PSRwrite;
`ifdef ALU_MULHI_EN
    logic [W-1:0] result_hi;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .arg1      (arg1),
        .arg2      (arg2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
`ifdef ALU_MULHI_EN
        .PSRwrite  (PSRwrite),
        .result_hi (result_hi)
`else
        .PSRwrite  (PSRwrite)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the opcode definitions.
    function automatic void model(input logic [2:0] op, input longint a, input longint b,
                                  output longint res, output longint hi, output logic [4:0] psr);
        longint m, half, sa, sb, s, sr, p;
        logic n, z, f, l, c;
        m = longint'(1) << W;
        half = longint'(1) << (W - 1);
        sa = (a >= half) ? a - m : a;
        sb = (b >= half) ? b - m : b;
        n = 0; z = 0; f = 0; l = 0; c = 0; hi = 0; res = 0;
        case (op)
            3'd0: begin s = a + b; res = s % m; c = (s >= m); sr = sa + sb; f = (sr >= half) || (sr < -half); end
            3'd1: begin res = (a - b + m) % m; c = (a < b); sr = sa - sb; f = (sr >= half) || (sr < -half); end
            3'd2: res = a | b;
            3'd3: res = a & b;
            3'd4: res = a ^ b;
            3'd5: res = (m - 1) - a;
            3'd6: begin
                p = a * b;
                res = p % m;
                hi = p / m;
`ifdef ALU_MULHI_EN
                f = (hi != 0);
`endif
            end
            default: begin res = a; z = (a == b); l = (a < b); n = (sa < sb); end
        endcase
        if (op != 3'd7) begin
            z = (res == 0);
            n = (res >= half);
        end
        psr = {n, z, f, l, c};
    endfunction

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int k = 0;
        while (in_ready !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk("in_ready_wait", k < 40, 1);
        aluop = op; arg1 = a; arg2 = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        arg1 = $urandom; arg2 = $urandom;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint er, eh;
        logic [4:0] ep;
        int lat = 1;
        model(op, longint'(a), longint'(b), er, eh, ep);
        send(op, a, b);
        if (op == 3'd6) chk("mul_in_ready_low", in_ready, 0);
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", lat, (op == 3'd6) ? W + 1 : 1);
        chk("result", result, er);
        chk("psr", PSRwrite, ep);
`ifdef ALU_MULHI_EN
        chk("result_hi", result_hi, eh);
`endif
    endtask

    initial begin
        longint er, eh;
        logic [4:0] ep;
        int hits;

        // Reset state
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_psr", PSRwrite, 0);
        reset = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1);

        // Directed test-plan vectors
        run_op(3'd0, 16'hFFFF, 16'h0001);
        chk("add_wrap_psr", PSRwrite, 5'b01001);
        run_op(3'd1, 16'h8000, 16'h0001);
        chk("sub_ovf_res", result, 16'h7FFF);
        chk("sub_ovf_psr", PSRwrite, 5'b00100);
        run_op(3'd1, 16'h0003, 16'h0005);
        chk("sub_borrow_psr", PSRwrite, 5'b10001);
        run_op(3'd7, 16'h0005, 16'h0007);
        chk("cmp_lt_psr", PSRwrite, 5'b10010);
        run_op(3'd7, 16'hFFFF, 16'h0001);
        chk("cmp_signed_psr", PSRwrite, 5'b10000);
        run_op(3'd7, 16'h1234, 16'h1234);
        chk("cmp_eq_psr", PSRwrite, 5'b01000);
        run_op(3'd6, 16'h0123, 16'h0010);
        chk("mult_res", result, 16'h1230);
        run_op(3'd5, 16'h00F0, 16'hAAAA);
        run_op(3'd6, 16'hFFFF, 16'hFFFF);
        chk("mult_full_lo", result, 16'h0001);
`ifdef ALU_MULHI_EN
        chk("mult_full_hi", result_hi, 16'hFFFE);
`endif

        // Random ops, back to back
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        end

        // Backpressure then same-edge transfer and accept
        model(3'd0, 64'h1234, 64'h8765, er, eh, ep);
        send(3'd0, 16'h1234, 16'h8765);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", result, er);
            chk("bp_psr", PSRwrite, ep);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        aluop = 3'd4; arg1 = 16'h00FF; arg2 = 16'h0F0F; in_valid = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_result", result, 16'h0FF0);
        chk("bp_next_psr", PSRwrite, 5'b00000);

        // Reset in the middle of a multiply
        send(3'd6, 16'h0123, 16'h0456);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_psr", PSRwrite, 0);
        tick(); tick();
        reset = 1'b1;
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid === 1'b1) hits++;
        end
        chk("abort_no_pulse", hits, 0);
        chk("abort_in_ready", in_ready, 1);
        run_op(3'd0, 16'h0002, 16'h0003);
        chk("post_rst_res", result, 16'h0005);
        chk("post_rst_psr", PSRwrite, 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Next-generation CPU ALU: WIDTH-parametrised and registered, with a valid/ready handshake on both sides.
- Keeps the 3-bit opcode set and the 5-bit PSR flag vector of the current datapath ALU.
- Replaces the combinational multiply with an iterative shift-add unit, so MULT is multi-cycle and all other ops take one cycle.
- Sits between the register-file read stage and writeback/PSR update.

Parameters:
- WIDTH, 16: operand and result width in bits, must be >= 4.
- CNT_W, $clog2(WIDTH+1): width of the multiply iteration counter (derived; do not override).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept an op
- aluop  in  3  ADD=000 SUB=001 OR=010 AND=011 XOR=100 NOT=101 MULT=110 CMP=111
- arg1  in  WIDTH  first operand
- arg2  in  WIDTH  second operand
- out_valid  out  1  result/PSRwrite valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  op result
- PSRwrite  out  5  flags {N,Z,F,L,C} = bits [4:0]

Behaviour:
- Reset (reset=0, async): state=IDLE; out_valid=0; result=0; PSRwrite=0; multiply counter=0.
- in_ready is 1 after reset release.
- Handshake:
  - Accept on a rising edge with in_valid && in_ready; operands are captured at that edge.
  - A result transfers on a rising edge with out_valid && out_ready.
  - While out_valid && !out_ready, result and PSRwrite hold stable.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back single-cycle ops therefore sustain 1 op/cycle.
- FSM:
  - IDLE: on accept of a non-MULT op -> DONE; on accept of MULT -> MUL.
  - MUL: WIDTH iterations, one bit per cycle (LSB-first shift-add). When the counter reaches WIDTH -> DONE.
  - DONE: out_valid=1. If out_ready: with a same-edge accept, go to DONE or MUL per the new op; without one, go to IDLE.
- Latency, accept edge to out_valid high: 1 cycle for non-MULT ops, WIDTH+1 cycles for MULT.
- Arithmetic is modulo 2^WIDTH.
  - ADD: C = carry out; F = signed overflow.
  - SUB: result = arg1-arg2; C = borrow (arg1<arg2 unsigned); F = signed overflow.
  - OR/AND/XOR: bitwise.
  - NOT: ~arg1, arg2 ignored.
  - MULT: low WIDTH bits of the unsigned product.
  - CMP: result=arg1; Z = (arg1==arg2); L = arg1<arg2 unsigned; N = arg1<arg2 signed; C=F=0.
- Flags for all non-CMP ops: Z = (result==0); N = result[WIDTH-1]. C and F are 0 except for ADD/SUB. L is 0 except for CMP.
- in_valid while in_ready=0 is ignored, not queued. Operand changes during MUL have no effect.
- reset asserted mid-MUL or mid-DONE aborts the op; the result is lost and no out_valid pulse occurs.

Optional Feature:
- Macro ALU_MULHI_EN.
- Defined:
  - Adds output port result_hi, WIDTH bits, carrying the upper product half for MULT.
  - result_hi is 0 for all other ops and at reset.
  - MULT flag F = (upper half != 0).
- Undefined:
  - result_hi port does not exist; the upper product bits are not stored.
  - MULT F = 0.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (ADD..CMP);
  - PSR bit indices (PSR_C=0, PSR_L=1, PSR_F=2, PSR_Z=3, PSR_N=4);
  - FSM state encodings (IDLE, MUL, DONE).
- One sub-module: alu_mult_iter.
  - Ports: start, operands, busy, done, WIDTH-bit product (2*WIDTH under ALU_MULHI_EN).
  - Contains the shift-add datapath and the iteration counter.
  - alu_seq owns the handshake, single-cycle ops and flags.

Test Plan (WIDTH=16):
- ADD 0xFFFF+0x0001 -> out_valid 1 cycle after accept; result=0x0000; C=1, Z=1, F=0, N=0.
- SUB 0x8000-0x0001 -> result=0x7FFF; F=1, C=0, N=0. SUB 0x0003-0x0005 -> result=0xFFFE; C=1, N=1.
- CMP 0x0005 vs 0x0007 -> L=1, N=1, Z=0, result=0x0005. CMP 0xFFFF vs 0x0001 -> L=0, N=1. CMP 0x1234 vs 0x1234 -> Z=1.
- MULT 0x0123*0x0010 -> in_ready=0 during MUL; out_valid exactly 17 cycles after accept; result=0x1230.
- Under ALU_MULHI_EN: 0xFFFF*0xFFFF -> result=0x0001, result_hi=0xFFFE, F=1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles -> result/PSRwrite stable and in_ready=0.
  - Raise out_ready with in_valid (XOR 0x00FF,0x0F0F) -> transfer and accept on the same edge; next result=0x0FF0.
- Reset:
  - Assert reset 5 cycles into a MULT -> out_valid=0 immediately and stays 0.
  - After release: in_ready=1; ADD 0x0002+0x0003 -> result=0x0005, PSRwrite=0.
